// File: rtl/input_fifo_handshake.sv
// Router input-port flit buffer: RTS/CTS capture into a circular FIFO.
// The head flit is popped on any output-arbiter grant.
module input_fifo_handshake #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          DRTS,
  input  logic [DATA_WIDTH-1:0]         RX,
  output logic                          CTS,
  input  logic                          read_en_N,
  input  logic                          read_en_E,
  input  logic                          read_en_W,
  input  logic                          read_en_S,
  input  logic                          read_en_L,
  output logic [DATA_WIDTH-1:0]         Data_out,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  cts_q, cts_d;
  logic                  accept_c;
  logic                  read_c;

  // Status flags decode straight from the registered occupancy.
  assign empty    = (count_q == CNT_W'(0));
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign CTS      = cts_q;
  assign Data_out = mem_q[rd_ptr_q];

  // CTS high blocks a new accept, so inbound flits are at least two cycles apart.
  assign accept_c = DRTS & ~cts_q & ~full;
  assign read_c   = (read_en_N | read_en_E | read_en_W | read_en_S | read_en_L) & ~empty;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    cts_d    = accept_c;
    if (accept_c) begin
      mem_d[wr_ptr_q] = RX;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (read_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({accept_c, read_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      cts_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      cts_q    <= cts_d;
    end
  end

endmodule

// File: tb/tb_input_fifo_handshake.sv
// Scoreboard bench for input_fifo_handshake: flits queued when sent, compared at each pop.
module tb_input_fifo_handshake;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          DRTS;
  logic [DW-1:0] RX;
  logic          CTS;
  logic          read_en_N, read_en_E, read_en_W, read_en_S, read_en_L;
  logic [DW-1:0] Data_out;
  logic          empty, full;
  logic [2:0]    count;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] sb [$];

  input_fifo_handshake #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .DRTS(DRTS), .RX(RX), .CTS(CTS),
    .read_en_N(read_en_N), .read_en_E(read_en_E), .read_en_W(read_en_W),
    .read_en_S(read_en_S), .read_en_L(read_en_L),
    .Data_out(Data_out), .empty(empty), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Raise DRTS with a flit, wait (bounded) for CTS, then drop DRTS.
  task automatic send(input logic [DW-1:0] d);
    bit seen = 0;
    DRTS = 1'b1;
    RX   = d;
    sb.push_back(d);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (CTS) begin seen = 1; break; end
    end
    if (!seen) chk("cts_timeout", 0, 1);
    DRTS = 1'b0;
  endtask

  // Drive grant mask {N,E,W,S,L} for one edge; head is checked against the scoreboard.
  task automatic grant(input logic [4:0] g);
    bit had = (sb.size() != 0);
    if (had) chk("head", Data_out, sb[0]);
    {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L} = g;
    @(posedge clk); #1;
    {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L} = '0;
    if (had) void'(sb.pop_front());
    chk("count_after_grant", 64'(count), 64'(sb.size()));
    chk("empty_after_grant", 64'(empty), 64'(sb.size() == 0));
  endtask

  task automatic drain();
    while (sb.size() != 0) grant(5'b00001);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; DRTS = 1'b0; RX = '0;
    {read_en_N, read_en_E, read_en_W, read_en_S, read_en_L} = '0;
    #2;
    chk("rst_cts", 64'(CTS), 0);
    chk("rst_empty", 64'(empty), 1);
    chk("rst_full", 64'(full), 0);
    chk("rst_count", 64'(count), 0);
    chk("rst_data", 64'(Data_out), 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Single flit from idle
    DRTS = 1'b1; RX = 32'hA5A5_0001;
    chk("single_cts_pre", 64'(CTS), 0);
    @(posedge clk); #1;
    chk("single_cts_hi", 64'(CTS), 1);
    chk("single_data", 64'(Data_out), 64'h0000_0000_A5A5_0001);
    chk("single_empty", 64'(empty), 0);
    chk("single_count", 64'(count), 1);
    DRTS = 1'b0;
    sb.push_back(32'hA5A5_0001);
    @(posedge clk); #1;
    chk("single_cts_lo", 64'(CTS), 0);
    grant(5'b01000);

    // Fill to full, blocked fifth flit, release by one read
    for (int i = 0; i < 4; i++) send(32'(32'h10 + i));
    chk("fill_full", 64'(full), 1);
    chk("fill_count", 64'(count), 4);
    DRTS = 1'b1; RX = 32'h14;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("blocked_cts", 64'(CTS), 0);
    end
    grant(5'b00001);
    chk("freed_cts_same", 64'(CTS), 0);
    sb.push_back(32'h14);
    @(posedge clk); #1;
    chk("freed_cts", 64'(CTS), 1);
    chk("refill_count", 64'(count), 4);
    DRTS = 1'b0;
    drain();

    // Wrap-around with occupancy 1..2
    for (int i = 0; i < 10; i++) begin
      send(32'(32'h20 + i));
      if (sb.size() == 2) grant(5'b00100);
    end
    drain();

    // Simultaneous accept and read at count=2
    send(32'h30); send(32'h31);
    @(posedge clk); #1;
    chk("sim_pre_count", 64'(count), 2);
    chk("sim_head", 64'(Data_out), 64'h30);
    DRTS = 1'b1; RX = 32'h32; read_en_W = 1'b1;
    @(posedge clk); #1;
    DRTS = 1'b0; read_en_W = 1'b0;
    void'(sb.pop_front());
    sb.push_back(32'h32);
    chk("sim_count", 64'(count), 2);
    chk("sim_cts", 64'(CTS), 1);
    chk("sim_new_head", 64'(Data_out), 64'h31);
    drain();

    // Grant abuse
    grant(5'b10000);
    chk("abuse_empty_full", 64'(full), 0);
    send(32'h40); send(32'h41);
    grant(5'b10010);
    chk("abuse_two_grants", 64'(count), 1);
    drain();

    // Asynchronous reset mid-stream with count=3
    send(32'h50); send(32'h51); send(32'h52);
    DRTS = 1'b1; RX = 32'h53;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("async_cts", 64'(CTS), 0);
    chk("async_empty", 64'(empty), 1);
    chk("async_count", 64'(count), 0);
    chk("async_data", 64'(Data_out), 0);
    DRTS = 1'b0;
    sb.delete();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    send(32'h60);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
